// File: rtl/tri_setup_if.sv
// Staging-register and rasterizer link for tri_setup.
// master = setup stage, slave = staging register / rasterizer side.
interface tri_setup_if #(
  parameter int COORD_W = 16
);
  logic                         i_ready;
  logic [95:0]                  i_vertex_in0;
  logic [95:0]                  i_vertex_in1;
  logic [95:0]                  i_vertex_in2;
  logic [95:0]                  i_color_in0;
  logic [95:0]                  i_color_in1;
  logic [95:0]                  i_color_in2;
  logic                         o_dequeue;
  logic                         o_tri_valid;
  logic                         i_tri_ready;
  logic [3*(COORD_W+1)-1:0]     o_edge_a;
  logic [3*(COORD_W+1)-1:0]     o_edge_b;
  logic [3*(2*COORD_W+2)-1:0]   o_edge_c;
  logic [2*COORD_W+3:0]         o_area2;
  logic [COORD_W-1:0]           o_bbox_xmin;
  logic [COORD_W-1:0]           o_bbox_xmax;
  logic [COORD_W-1:0]           o_bbox_ymin;
  logic [COORD_W-1:0]           o_bbox_ymax;
  logic [95:0]                  o_z_out;
  logic [287:0]                 o_color_out;
  logic                         o_tri_dropped;

  modport master (
    input  i_ready, i_vertex_in0, i_vertex_in1, i_vertex_in2,
           i_color_in0, i_color_in1, i_color_in2, i_tri_ready,
    output o_dequeue, o_tri_valid, o_edge_a, o_edge_b, o_edge_c, o_area2,
           o_bbox_xmin, o_bbox_xmax, o_bbox_ymin, o_bbox_ymax,
           o_z_out, o_color_out, o_tri_dropped
  );

  modport slave (
    output i_ready, i_vertex_in0, i_vertex_in1, i_vertex_in2,
           i_color_in0, i_color_in1, i_color_in2, i_tri_ready,
    input  o_dequeue, o_tri_valid, o_edge_a, o_edge_b, o_edge_c, o_area2,
           o_bbox_xmin, o_bbox_xmax, o_bbox_ymin, o_bbox_ymax,
           o_z_out, o_color_out, o_tri_dropped
  );
endinterface

// File: rtl/tri_setup.sv
// Triangle setup: edge coefficients, double area and clamped bbox from a staged triangle.
// Define CULL_BACKFACE_EN to drop clockwise triangles instead of normalising them.
module tri_setup #(
  parameter int COORD_W  = 16,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  tri_setup_if.master bus
);
  localparam int AW  = COORD_W + 1;
  localparam int PW  = 2 * COORD_W;
  localparam int CWD = 2 * COORD_W + 2;
  localparam int SWD = 2 * COORD_W + 4;
  localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W);
  localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H);
  localparam logic signed [COORD_W-1:0] X_HI  = COORD_W'(SCREEN_W - 1);
  localparam logic signed [COORD_W-1:0] Y_HI  = COORD_W'(SCREEN_H - 1);

  // state  | meaning
  // IDLE   | wait for staged triangle    LATCH | capture vertices, A/B
  // MUL0-5 | one shared product each     SUM   | C, area2, bbox, drop/winding
  // EMIT   | hold result until accepted  DEQ   | dequeue pulse, then IDLE
  typedef enum logic [3:0] {
    S_IDLE, S_LATCH, S_MUL0, S_MUL1, S_MUL2, S_MUL3, S_MUL4, S_MUL5,
    S_SUM, S_EMIT, S_DEQ
  } state_t;

  state_t                    r_state;
  logic signed [COORD_W-1:0] r_x [3];
  logic signed [COORD_W-1:0] r_y [3];
  logic signed [AW-1:0]      r_a [3];
  logic signed [AW-1:0]      r_b [3];
  logic signed [PW-1:0]      r_prod [6];
  logic [95:0]               r_z;
  logic [287:0]              r_col;
  logic                      r_dequeue, r_tri_valid, r_tri_dropped;
  logic [3*AW-1:0]           r_edge_a, r_edge_b;
  logic [3*CWD-1:0]          r_edge_c;
  logic signed [SWD-1:0]     r_area2;
  logic [COORD_W-1:0]        r_xmin, r_xmax, r_ymin, r_ymax;
  logic [95:0]               r_z_out;
  logic [287:0]              r_color_out;

  logic signed [COORD_W-1:0] w_xin [3];
  logic signed [COORD_W-1:0] w_yin [3];
  logic signed [AW-1:0]      w_ain [3];
  logic signed [AW-1:0]      w_bin [3];
  logic signed [COORD_W-1:0] w_mul_a, w_mul_b;
  logic signed [PW-1:0]      w_prod;
  logic signed [CWD-1:0]     w_c [3];
  logic signed [SWD-1:0]     w_area;
  logic signed [COORD_W-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
  logic                      w_neg, w_cull, w_drop;

  function automatic logic signed [COORD_W-1:0] min3(
    input logic signed [COORD_W-1:0] a, b, c);
    logic signed [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [COORD_W-1:0] max3(
    input logic signed [COORD_W-1:0] a, b, c);
    logic signed [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [COORD_W-1:0] clamp(
    input logic signed [COORD_W-1:0] v, hi);
    if (v[COORD_W-1]) return '0;
    return (v > hi) ? hi : v;
  endfunction

  assign w_xin[0] = bus.i_vertex_in0[64 +: COORD_W];
  assign w_xin[1] = bus.i_vertex_in1[64 +: COORD_W];
  assign w_xin[2] = bus.i_vertex_in2[64 +: COORD_W];
  assign w_yin[0] = bus.i_vertex_in0[32 +: COORD_W];
  assign w_yin[1] = bus.i_vertex_in1[32 +: COORD_W];
  assign w_yin[2] = bus.i_vertex_in2[32 +: COORD_W];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_ain[i] = AW'(w_yin[i]) - AW'(w_yin[(i + 1) % 3]);
      w_bin[i] = AW'(w_xin[(i + 1) % 3]) - AW'(w_xin[i]);
    end
  end

  // Operand order fixes which product lands in which r_prod slot.
  always_comb begin
    w_mul_a = r_x[0];
    w_mul_b = r_y[1];
    case (r_state)
      S_MUL1:  begin w_mul_a = r_x[1]; w_mul_b = r_y[0]; end
      S_MUL2:  begin w_mul_a = r_x[1]; w_mul_b = r_y[2]; end
      S_MUL3:  begin w_mul_a = r_x[2]; w_mul_b = r_y[1]; end
      S_MUL4:  begin w_mul_a = r_x[2]; w_mul_b = r_y[0]; end
      S_MUL5:  begin w_mul_a = r_x[0]; w_mul_b = r_y[2]; end
      default: ;
    endcase
  end

  assign w_prod = w_mul_a * w_mul_b;

  always_comb begin
    w_c[0] = CWD'(r_prod[0]) - CWD'(r_prod[1]);
    w_c[1] = CWD'(r_prod[2]) - CWD'(r_prod[3]);
    w_c[2] = CWD'(r_prod[4]) - CWD'(r_prod[5]);
    w_area = SWD'(w_c[0]) + SWD'(w_c[1]) + SWD'(w_c[2]);
  end

  assign w_xmin = min3(r_x[0], r_x[1], r_x[2]);
  assign w_xmax = max3(r_x[0], r_x[1], r_x[2]);
  assign w_ymin = min3(r_y[0], r_y[1], r_y[2]);
  assign w_ymax = max3(r_y[0], r_y[1], r_y[2]);
  assign w_neg  = w_area[SWD-1];

`ifdef CULL_BACKFACE_EN
  assign w_cull = w_neg;
`else
  assign w_cull = 1'b0;
`endif

  assign w_drop = (w_area == '0) || w_cull || w_xmax[COORD_W-1] || w_ymax[COORD_W-1] ||
                  (w_xmin >= X_LIM) || (w_ymin >= Y_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      for (int i = 0; i < 3; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
      for (int i = 0; i < 6; i++) r_prod[i] <= '0;
      r_z           <= '0;
      r_col         <= '0;
      r_dequeue     <= 1'b0;
      r_tri_valid   <= 1'b0;
      r_tri_dropped <= 1'b0;
      r_edge_a      <= '0;
      r_edge_b      <= '0;
      r_edge_c      <= '0;
      r_area2       <= '0;
      r_xmin        <= '0;
      r_xmax        <= '0;
      r_ymin        <= '0;
      r_ymax        <= '0;
      r_z_out       <= '0;
      r_color_out   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.i_ready) r_state <= S_LATCH;
        S_LATCH: begin
          for (int i = 0; i < 3; i++) begin
            r_x[i] <= w_xin[i];
            r_y[i] <= w_yin[i];
            r_a[i] <= w_ain[i];
            r_b[i] <= w_bin[i];
          end
          r_z   <= {bus.i_vertex_in2[31:0], bus.i_vertex_in1[31:0], bus.i_vertex_in0[31:0]};
          r_col <= {bus.i_color_in2, bus.i_color_in1, bus.i_color_in0};
          r_state <= S_MUL0;
        end
        S_MUL0: begin r_prod[0] <= w_prod; r_state <= S_MUL1; end
        S_MUL1: begin r_prod[1] <= w_prod; r_state <= S_MUL2; end
        S_MUL2: begin r_prod[2] <= w_prod; r_state <= S_MUL3; end
        S_MUL3: begin r_prod[3] <= w_prod; r_state <= S_MUL4; end
        S_MUL4: begin r_prod[4] <= w_prod; r_state <= S_MUL5; end
        S_MUL5: begin r_prod[5] <= w_prod; r_state <= S_SUM;  end
        S_SUM: begin
          if (w_drop) begin
            r_tri_dropped <= 1'b1;
            r_dequeue     <= 1'b1;
            r_state       <= S_DEQ;
          end else begin
            // Clockwise triangles are flipped so area2 is always positive downstream.
            for (int i = 0; i < 3; i++) begin
              r_edge_a[i*AW +: AW]   <= w_neg ? -r_a[i] : r_a[i];
              r_edge_b[i*AW +: AW]   <= w_neg ? -r_b[i] : r_b[i];
              r_edge_c[i*CWD +: CWD] <= w_neg ? -w_c[i] : w_c[i];
            end
            r_area2     <= w_neg ? -w_area : w_area;
            r_xmin      <= clamp(w_xmin, X_HI);
            r_xmax      <= clamp(w_xmax, X_HI);
            r_ymin      <= clamp(w_ymin, Y_HI);
            r_ymax      <= clamp(w_ymax, Y_HI);
            r_z_out     <= r_z;
            r_color_out <= r_col;
            r_tri_valid <= 1'b1;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: if (bus.i_tri_ready) begin
          r_tri_valid <= 1'b0;
          r_dequeue   <= 1'b1;
          r_state     <= S_DEQ;
        end
        S_DEQ: begin
          r_dequeue     <= 1'b0;
          r_tri_dropped <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_dequeue     = r_dequeue;
  assign bus.o_tri_valid   = r_tri_valid;
  assign bus.o_tri_dropped = r_tri_dropped;
  assign bus.o_edge_a      = r_edge_a;
  assign bus.o_edge_b      = r_edge_b;
  assign bus.o_edge_c      = r_edge_c;
  assign bus.o_area2       = r_area2;
  assign bus.o_bbox_xmin   = r_xmin;
  assign bus.o_bbox_xmax   = r_xmax;
  assign bus.o_bbox_ymin   = r_ymin;
  assign bus.o_bbox_ymax   = r_ymax;
  assign bus.o_z_out       = r_z_out;
  assign bus.o_color_out   = r_color_out;
endmodule

// File: tb/tb_tri_setup.sv
// Self-checking bench for tri_setup: arithmetic reference model plus directed triangles.
module tb_tri_setup;
  localparam int CW = 16;
`ifdef CULL_BACKFACE_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tri_setup_if #(.COORD_W(CW)) bus ();
  tri_setup #(.COORD_W(CW), .SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_vec = 0;
  int n_err = 0;

  longint e_a [3];
  longint e_b [3];
  longint e_c [3];
  longint e_area, e_xmin, e_xmax, e_ymin, e_ymax;
  bit     e_drop;
  logic [50:0]  x_edge_a, x_edge_b;
  logic [101:0] x_edge_c;
  logic [35:0]  x_area;
  logic [63:0]  x_bbox;
  logic [95:0]  x_z;
  logic [287:0] x_col;

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic longint lclamp(input longint v, input longint hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [9:0] out_bits();
    return {bus.o_dequeue, bus.o_tri_valid, bus.o_tri_dropped, |bus.o_edge_a,
            |bus.o_edge_b, |bus.o_edge_c, |bus.o_area2,
            |{bus.o_bbox_xmin, bus.o_bbox_xmax, bus.o_bbox_ymin, bus.o_bbox_ymax},
            |bus.o_z_out, |bus.o_color_out};
  endfunction

  // Reference: area from the cross product of two edge vectors, coefficients from their definitions.
  task automatic model(input longint x0, y0, x1, y1, x2, y2);
    longint xs [3];
    longint ys [3];
    longint s, mnx, mxx, mny, mxy;
    xs[0] = x0; xs[1] = x1; xs[2] = x2;
    ys[0] = y0; ys[1] = y1; ys[2] = y2;
    e_area = (x1 - x0) * (y2 - y0) - (x2 - x0) * (y1 - y0);
    s = (e_area < 0) ? -1 : 1;
    for (int i = 0; i < 3; i++) begin
      e_a[i] = s * (ys[i] - ys[(i + 1) % 3]);
      e_b[i] = s * (xs[(i + 1) % 3] - xs[i]);
      e_c[i] = s * (xs[i] * ys[(i + 1) % 3] - xs[(i + 1) % 3] * ys[i]);
    end
    mnx = xs[0]; mxx = xs[0]; mny = ys[0]; mxy = ys[0];
    for (int i = 1; i < 3; i++) begin
      if (xs[i] < mnx) mnx = xs[i];
      if (xs[i] > mxx) mxx = xs[i];
      if (ys[i] < mny) mny = ys[i];
      if (ys[i] > mxy) mxy = ys[i];
    end
    e_drop = (e_area == 0) || (mxx < 0) || (mnx >= 640) || (mxy < 0) || (mny >= 480) ||
             (CULL && (e_area < 0));
    e_area = s * e_area;
    e_xmin = lclamp(mnx, 639); e_xmax = lclamp(mxx, 639);
    e_ymin = lclamp(mny, 479); e_ymax = lclamp(mxy, 479);
    x_edge_a = {17'(e_a[2]), 17'(e_a[1]), 17'(e_a[0])};
    x_edge_b = {17'(e_b[2]), 17'(e_b[1]), 17'(e_b[0])};
    x_edge_c = {34'(e_c[2]), 34'(e_c[1]), 34'(e_c[0])};
    x_area   = 36'(e_area);
    x_bbox   = {16'(e_xmin), 16'(e_xmax), 16'(e_ymin), 16'(e_ymax)};
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_tri_valid) begin
      chk("unexpected_valid", bus.o_tri_valid & e_drop, 1'b0);
      chk("edge_a", bus.o_edge_a, x_edge_a);
      chk("edge_b", bus.o_edge_b, x_edge_b);
      chk("edge_c", bus.o_edge_c, x_edge_c);
      chk("area2", bus.o_area2, x_area);
      chk("bbox", {bus.o_bbox_xmin, bus.o_bbox_xmax, bus.o_bbox_ymin, bus.o_bbox_ymax}, x_bbox);
      chk("z_out", bus.o_z_out, x_z);
      chk("color_out", bus.o_color_out, x_col);
      chk("dequeue_while_valid", bus.o_dequeue, 1'b0);
    end
  end

  task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input int hold, input int rst_k);
    int k, k_valid, k_dq, n_dq, n_drop, n_hold, rk;
    bit done;
    logic [31:0] z [3];
    logic [95:0] c [3];
    for (int i = 0; i < 3; i++) begin
      z[i] = $urandom;
      c[i] = {$urandom, $urandom, $urandom};
    end
    model(x0, y0, x1, y1, x2, y2);
    x_z   = {z[2], z[1], z[0]};
    x_col = {c[2], c[1], c[0]};
    @(negedge clk);
    bus.i_vertex_in0 = {16'hA5A5, 16'(x0), 16'h5A5A, 16'(y0), z[0]};
    bus.i_vertex_in1 = {16'hA5A5, 16'(x1), 16'h5A5A, 16'(y1), z[1]};
    bus.i_vertex_in2 = {16'hA5A5, 16'(x2), 16'h5A5A, 16'(y2), z[2]};
    bus.i_color_in0 = c[0];
    bus.i_color_in1 = c[1];
    bus.i_color_in2 = c[2];
    bus.i_ready     = 1'b1;
    bus.i_tri_ready = (hold == 0);
    k = 0; k_valid = -1; k_dq = -1; n_dq = 0; n_drop = 0; n_hold = 0; rk = rst_k; done = 0;
    for (int t = 0; t < 150 && !done; t++) begin
      @(posedge clk); #1;
      k++;
      if (rk != 0 && k == rk) begin
        rst = 1'b1;
        #1;
        chk("reset_mid_clears", out_bits(), '0);
        @(negedge clk);
        rst = 1'b0;
        rk = 0;
        k = 0;
        continue;
      end
      if (bus.o_tri_valid && k_valid < 0) k_valid = k;
      if (bus.o_tri_dropped) n_drop++;
      if (bus.o_dequeue) begin
        n_dq++;
        if (k_dq < 0) begin
          k_dq = k;
          bus.i_ready = 1'b0;
        end
      end else if (k_dq >= 0) begin
        done = 1;
      end
      if (bus.o_tri_valid && !bus.i_tri_ready) begin
        n_hold++;
        if (n_hold >= hold) bus.i_tri_ready = 1'b1;
      end
    end
    chk("completed_in_budget", done, 1'b1);
    chk("dequeue_pulses", n_dq, 1);
    chk("dropped_pulses", n_drop, e_drop);
    if (e_drop) begin
      chk("no_valid_on_drop", k_valid, -1);
      chk("drop_dequeue_cycle", k_dq, 9);
    end else begin
      chk("valid_latency", k_valid, 9);
      chk("dequeue_cycle", k_dq, 9 + ((hold > 1) ? hold : 1));
    end
    repeat (2) @(posedge clk);
  endtask

  logic [50:0]  lit_a;
  logic [50:0]  lit_b;
  logic [101:0] lit_c;

  initial begin
    bus.i_ready = 1'b0;
    bus.i_tri_ready = 1'b0;
    bus.i_vertex_in0 = '0; bus.i_vertex_in1 = '0; bus.i_vertex_in2 = '0;
    bus.i_color_in0 = '0; bus.i_color_in1 = '0; bus.i_color_in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", out_bits(), '0);
    @(negedge clk);
    rst = 1'b0;

    // Counter-clockwise right triangle
    run_tri(0, 0, 10, 0, 0, 10, 0, 0);
    chk("model_area_t1", e_area, 100);
    chk("model_c1_t1", e_c[1], 100);
    lit_a = {17'sd10, -17'sd10, 17'sd0};
    lit_b = {17'sd0, -17'sd10, 17'sd10};
    lit_c = {34'sd0, 34'sd100, 34'sd0};
    chk("t1_edge_a", bus.o_edge_a, lit_a);
    chk("t1_edge_b", bus.o_edge_b, lit_b);
    chk("t1_edge_c", bus.o_edge_c, lit_c);
    chk("t1_area2", bus.o_area2, 36'd100);
    chk("t1_bbox", {bus.o_bbox_xmin, bus.o_bbox_xmax, bus.o_bbox_ymin, bus.o_bbox_ymax},
        {16'd0, 16'd10, 16'd0, 16'd10});

    // Clockwise version of the same triangle
    run_tri(0, 0, 0, 10, 10, 0, 0, 0);
`ifndef CULL_BACKFACE_EN
    lit_a = {17'sd0, -17'sd10, 17'sd10};
    chk("t2_edge_a", bus.o_edge_a, lit_a);
    chk("t2_area2", bus.o_area2, 36'd100);
`endif

    run_tri(0, 0, 5, 5, 10, 10, 0, 0);
    chk("model_collinear_drop", e_drop, 1'b1);

    run_tri(-5, -5, 700, -5, -5, 500, 0, 0);
    chk("clamp_bbox", {bus.o_bbox_xmin, bus.o_bbox_xmax, bus.o_bbox_ymin, bus.o_bbox_ymax},
        {16'd0, 16'd639, 16'd0, 16'd479});

    run_tri(700, 0, 710, 0, 700, 10, 0, 0);

    run_tri(3, 4, 50, 7, 20, 60, 20, 0);

    run_tri(2, 3, 40, 5, 10, 30, 0, 5);

    run_tri(-1000, 300, 32000, -32000, 100, 32767, 0, 0);
    run_tri(32767, -32768, -32768, 32767, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
